// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
// Merges EX/MEM stall requests, branch mispredicts and load-use hazards
// into per-register stall/flush vectors and the PC redirect. Owns the
// pending-redirect state, the stall watchdog and two performance counters.
module pipe_ctrl #(
   parameter int MAX_STALL  = 64,
   parameter int REG_ADDR_W = 5,
   parameter int LS_W       = 3,
   parameter int REG_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_reg1addr,
   input  logic [REG_ADDR_W-1:0] id_reg2addr,
   input  logic                  id_reg1en,
   input  logic                  id_reg2en,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_regwe,
   input  logic [LS_W-1:0]       ex_loadctl,
   input  logic                  ex_stallreq,
   input  logic                  mem_stallreq,
   input  logic                  br_mispredict,
   input  logic [REG_W-1:0]      br_target,
   output logic [4:0]            stall,
   output logic [4:0]            flush,
   output logic                  redirect_valid,
   output logic [REG_W-1:0]      redirect_pc,
   output logic                  stall_timeout,
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_redirects
);

   typedef enum logic {RUN, PEND} state_t;

   // hold_cnt value seen during the last held cycle before the flag sets
   localparam logic [15:0] CNT_LIMIT = 16'(MAX_STALL - 1);

   state_t           state;
   logic [REG_W-1:0] pend_pc;
   logic [15:0]      hold_cnt;
   logic             hold;
   logic             lu;
   logic             redirect;

   // Counters stick at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign hold = mem_stallreq | ex_stallreq;

   // A load in EX whose destination feeds an ID source needs one bubble;
   // x0 never creates a dependency.
   assign lu = (ex_loadctl != '0) && ex_regwe && (ex_rd != '0) &&
               ((id_reg1en && (id_reg1addr == ex_rd)) ||
                (id_reg2en && (id_reg2addr == ex_rd)));

   // A later mispredict while pending cannot occur (EX frozen), so PEND wins
   assign redirect = (state == PEND) || br_mispredict;

   // Priority encode the control vectors; everything is quiet during reset
   always_comb begin
      stall          = 5'b00000;
      flush          = 5'b00000;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (rst) begin
         if (mem_stallreq) begin
            stall = 5'b01111;
            flush = 5'b10000;
         end else if (ex_stallreq) begin
            stall = 5'b00111;
            flush = 5'b01000;
         end else if (redirect) begin
            // Redirect beats LU: the hazarding instruction is flushed anyway
            flush          = 5'b00110;
            redirect_valid = 1'b1;
            redirect_pc    = (state == PEND) ? pend_pc : br_target;
         end else if (lu) begin
            stall = 5'b00011;
            flush = 5'b00100;
         end
      end
   end

   // Latch a mispredict that arrives under hold; release it once unheld
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RUN;
         pend_pc <= '0;
      end else begin
         case (state)
            RUN: begin
               if (br_mispredict && hold) begin
                  state   <= PEND;
                  pend_pc <= br_target;
               end
            end
            PEND: begin
               if (!hold) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // Watchdog: count consecutive held cycles, set a sticky flag at the limit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt      <= '0;
         stall_timeout <= 1'b0;
      end else if (hold) begin
         if (hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
         if (hold_cnt == CNT_LIMIT) stall_timeout <= 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end

   // Performance counters: frozen-PC cycles and issued redirects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cycles <= '0;
         perf_redirects    <= '0;
      end else begin
         if (stall[0])       perf_stall_cycles <= sat_inc(perf_stall_cycles);
         if (redirect_valid) perf_redirects    <= sat_inc(perf_redirects);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural reference model.
module tb_pipe_ctrl;

   localparam int MAX_ST = 4;

   logic        clk;
   logic        rst;
   logic [4:0]  id_reg1addr, id_reg2addr, ex_rd;
   logic        id_reg1en, id_reg2en, ex_regwe;
   logic [2:0]  ex_loadctl;
   logic        ex_stallreq, mem_stallreq, br_mispredict;
   logic [31:0] br_target;
   logic [4:0]  stall, flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall_timeout;
   logic [31:0] perf_stall_cycles, perf_redirects;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit          m_pend;
   logic [31:0] m_pend_pc;
   int          m_consec;
   bit          m_to;
   longint      m_stc, m_rdc;

   pipe_ctrl #(.MAX_STALL(MAX_ST), .REG_ADDR_W(5), .LS_W(3), .REG_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_reg1addr(id_reg1addr), .id_reg2addr(id_reg2addr),
      .id_reg1en(id_reg1en), .id_reg2en(id_reg2en),
      .ex_rd(ex_rd), .ex_regwe(ex_regwe), .ex_loadctl(ex_loadctl),
      .ex_stallreq(ex_stallreq), .mem_stallreq(mem_stallreq),
      .br_mispredict(br_mispredict), .br_target(br_target),
      .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall_timeout(stall_timeout),
      .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_pend_pc = '0; m_consec = 0; m_to = 0; m_stc = 0; m_rdc = 0;
   endtask

   task automatic idle();
      id_reg1addr = '0; id_reg2addr = '0; id_reg1en = 0; id_reg2en = 0;
      ex_rd = '0; ex_regwe = 0; ex_loadctl = '0;
      ex_stallreq = 0; mem_stallreq = 0; br_mispredict = 0; br_target = '0;
   endtask

   // Expected combinational outputs from the priority rules
   task automatic expect_outs(output logic [4:0] es, output logic [4:0] ef,
                              output logic erv, output logic [31:0] epc);
      bit lu;
      lu = (ex_loadctl != 0) && ex_regwe && (ex_rd != 0) &&
           ((id_reg1en && id_reg1addr == ex_rd) || (id_reg2en && id_reg2addr == ex_rd));
      es = 5'b00000; ef = 5'b00000; erv = 0; epc = 32'h0;
      if (mem_stallreq)                begin es = 5'b01111; ef = 5'b10000; end
      else if (ex_stallreq)            begin es = 5'b00111; ef = 5'b01000; end
      else if (m_pend || br_mispredict) begin
         ef = 5'b00110; erv = 1; epc = m_pend ? m_pend_pc : br_target;
      end
      else if (lu)                     begin es = 5'b00011; ef = 5'b00100; end
   endtask

   // Check one cycle against the model, then advance model and clock
   task automatic step(input string tag);
      logic [4:0]  es, ef;
      logic        erv;
      logic [31:0] epc;
      bit          held;
      #2;
      expect_outs(es, ef, erv, epc);
      chk({tag, ".stall"},   32'(stall), 32'(es));
      chk({tag, ".flush"},   32'(flush), 32'(ef));
      chk({tag, ".rv"},      32'(redirect_valid), 32'(erv));
      chk({tag, ".rpc"},     redirect_pc, epc);
      chk({tag, ".timeout"}, 32'(stall_timeout), 32'(m_to));
      chk({tag, ".pstall"},  perf_stall_cycles, m_stc[31:0]);
      chk({tag, ".predir"},  perf_redirects, m_rdc[31:0]);
      held = mem_stallreq || ex_stallreq;
      @(posedge clk);
      if (es[0] && m_stc < 64'hFFFF_FFFF) m_stc++;
      if (erv && m_rdc < 64'hFFFF_FFFF)   m_rdc++;
      m_consec = held ? m_consec + 1 : 0;
      if (m_consec >= MAX_ST) m_to = 1;
      if (m_pend) begin
         if (!held) m_pend = 0;
      end else if (br_mispredict && held) begin
         m_pend = 1; m_pend_pc = br_target;
      end
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst.stall", 32'(stall), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst.timeout", 32'(stall_timeout), 32'h0);
      chk("rst.pstall", perf_stall_cycles, 32'h0);
      chk("rst.predir", perf_redirects, 32'h0);
      rst = 1'b1;
      step("idle");

      // Load-use with rd=5 on source 2: one bubble, then quiet
      ex_loadctl = 3'd1; ex_regwe = 1; ex_rd = 5'd5; id_reg2en = 1; id_reg2addr = 5'd5;
      #1;
      chk("lu.stall", 32'(stall), 32'h03);
      chk("lu.flush", 32'(flush), 32'h04);
      step("lu");
      ex_loadctl = 3'd0; ex_regwe = 0;
      step("lu_bubble");
      ex_loadctl = 3'd1; ex_regwe = 1; ex_rd = 5'd0; id_reg2addr = 5'd0;
      #1;
      chk("lu_x0.stall", 32'(stall), 32'h0);
      step("lu_x0");
      idle();

      // Unheld mispredict redirects in the same cycle
      br_mispredict = 1; br_target = 32'h80;
      #1;
      chk("br.rv", 32'(redirect_valid), 32'h1);
      chk("br.rpc", redirect_pc, 32'h80);
      step("br");
      idle();
      chk("br.predir", perf_redirects, 32'h1);
      step("br_after");

      // Mispredict under a 3-cycle MEM hold is issued once when released
      mem_stallreq = 1; br_mispredict = 1; br_target = 32'h200;
      step("memh0");
      br_mispredict = 0; br_target = 32'hDEAD;
      step("memh1");
      step("memh2");
      mem_stallreq = 0;
      #1;
      chk("memh.rv", 32'(redirect_valid), 32'h1);
      chk("memh.rpc", redirect_pc, 32'h200);
      step("memh_rel");
      #1;
      chk("memh.once", 32'(redirect_valid), 32'h0);
      step("memh_after");

      // Both stall requests plus LU: MEM priority
      mem_stallreq = 1; ex_stallreq = 1;
      ex_loadctl = 3'd2; ex_regwe = 1; ex_rd = 5'd7; id_reg1en = 1; id_reg1addr = 5'd7;
      #1;
      chk("both.stall", 32'(stall), 32'h0F);
      chk("both.flush", 32'(flush), 32'h10);
      step("both");
      idle();
      step("both_after");

      // Watchdog with EX held for 6 cycles
      for (int i = 0; i < 6; i++) begin
         ex_stallreq = 1;
         #1;
         if (i == 3) chk("wd.pre", 32'(stall_timeout), 32'h0);
         if (i == 4) chk("wd.set", 32'(stall_timeout), 32'h1);
         step("wd");
      end
      idle();
      step("wd_rel");
      chk("wd.sticky", 32'(stall_timeout), 32'h1);

      // Reset while a redirect is pending discards it
      mem_stallreq = 1; br_mispredict = 1; br_target = 32'h3C0;
      step("pend");
      br_mispredict = 0;
      #2;
      rst = 1'b0;
      #1;
      chk("prst.stall", 32'(stall), 32'h0);
      chk("prst.flush", 32'(flush), 32'h0);
      chk("prst.rv", 32'(redirect_valid), 32'h0);
      chk("prst.rpc", redirect_pc, 32'h0);
      chk("prst.timeout", 32'(stall_timeout), 32'h0);
      chk("prst.pstall", perf_stall_cycles, 32'h0);
      chk("prst.predir", perf_redirects, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      mem_stallreq = 0;
      #1;
      chk("prst.norv", 32'(redirect_valid), 32'h0);
      step("prst_rel");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         mem_stallreq  = ($urandom_range(0, 5) == 0);
         ex_stallreq   = ($urandom_range(0, 5) == 0);
         br_mispredict = ($urandom_range(0, 6) == 0);
         br_target     = $urandom;
         ex_loadctl    = 3'($urandom_range(0, 3));
         ex_regwe      = 1'($urandom_range(0, 1));
         ex_rd         = 5'($urandom_range(0, 3));
         id_reg1en     = 1'($urandom_range(0, 1));
         id_reg2en     = 1'($urandom_range(0, 1));
         id_reg1addr   = 5'($urandom_range(0, 3));
         id_reg2addr   = 5'($urandom_range(0, 3));
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. Each cycle it combines stall requests from EX and MEM, the branch-mispredict pulse from the branch unit, and the load-use hazard condition between decode and execute. From these it drives per-register stall and flush vectors and the PC redirect. It sits beside the datapath and owns the pending-redirect state, a stall watchdog and two performance counters.

## Interface
- `MAX_STALL`, 64: consecutive held cycles after which `stall_timeout` sets (range 2..65535).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `id_reg1addr` / `id_reg2addr` in `RegAddrBus`: source register addresses of the instruction in ID.
- `id_reg1en` / `id_reg2en` in 1: the matching source is read.
- `ex_rd` in `RegAddrBus`: destination register of the instruction in EX.
- `ex_regwe` in 1: the EX instruction writes a register.
- `ex_loadctl` in `LSBus`: load control of the EX instruction; zero means not a load.
- `ex_stallreq` in 1: EX needs more cycles.
- `mem_stallreq` in 1: MEM is waiting on data memory.
- `br_mispredict` in 1: single-cycle pulse when EX resolves a mispredicted branch.
- `br_target` in `RegBus`: correct PC, valid with `br_mispredict`.
- `stall` out 5: hold enables. Bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB.
- `flush` out 5: bubble-insert enables, same bit map.
- `redirect_valid` out 1: load `redirect_pc` into PC this cycle.
- `redirect_pc` out `RegBus`: redirect target.
- `stall_timeout` out 1: sticky watchdog flag.
- `perf_stall_cycles` out 32: cycles with `stall[0]` = 1, saturating.
- `perf_redirects` out 32: redirects issued, saturating.

## Operation
- Hold: `hold = mem_stallreq | ex_stallreq`.
- Load-use hazard (LU): `ex_loadctl != 0`, `ex_regwe` = 1, `ex_rd != 0`, and (`id_reg1en` with `id_reg1addr == ex_rd`, or `id_reg2en` with `id_reg2addr == ex_rd`).
- States:
  - RUN: no pending redirect.
  - PEND: redirect latched, waiting for the hold to clear.
- Output priority, highest first:
  1. `mem_stallreq`: `stall` = 01111, `flush` = 10000.
  2. `ex_stallreq`: `stall` = 00111, `flush` = 01000.
  3. Redirect (state PEND, or RUN with `br_mispredict`): `stall` = 0, `flush` = 00110, `redirect_valid` = 1. `redirect_pc` comes from the pending register in PEND, otherwise from `br_target`.
  4. LU: `stall` = 00011, `flush` = 00100.
  5. Otherwise all zero.
- A redirect overrides LU because the hazarding instruction is being flushed.
- Transitions:
  - RUN, `br_mispredict` and `hold` → PEND, latch `br_target`.
  - PEND, `!hold` → RUN; the redirect is issued this cycle.
  - A new `br_mispredict` while in PEND is ignored. It cannot legally occur, because EX is frozen.
- Watchdog: `hold_cnt` (16 bit) increments on each held cycle and clears when `hold` = 0. When `hold_cnt` reaches `MAX_STALL - 1` while still held, `stall_timeout` sets. It stays set until reset and does not alter `stall` or `flush`.
- `perf_stall_cycles` increments on any cycle with `stall[0]` = 1, including LU. `perf_redirects` increments on each cycle with `redirect_valid` = 1. Both hold at 0xFFFFFFFF.

## Timing
- `stall`, `flush`, `redirect_valid` and `redirect_pc` are combinational from the inputs and state, valid in the same cycle as the request. `redirect_pc` is 0 when `redirect_valid` = 0.
- State, pending target, `hold_cnt`, `stall_timeout` and the counters are registered on the rising edge of `clk`.
- Reset (`rst` low, asynchronous): state RUN, pending target 0, `hold_cnt` 0, `stall_timeout` 0, counters 0. `stall`, `flush`, `redirect_valid` and `redirect_pc` are forced to 0 while `rst` is low.
- Reset asserted in PEND discards the pending redirect. The first cycle after release is RUN.
- LU costs exactly one bubble: the next cycle EX holds the bubble, so LU deasserts.
- Redirect latency:
  - 0 cycles when unheld.
  - When held, issued in the first cycle `hold` = 0, and only once.
- Watchdog: with continuous hold starting at cycle 0, `stall_timeout` reads 1 from cycle `MAX_STALL` onward.

## Test plan
- LU: EX load with `ex_rd` = 5, ID uses `id_reg2addr` = 5 → one cycle of `stall` = 00011, `flush` = 00100, then zero. Repeat with `ex_rd` = 0 → no stall.
- `br_mispredict` with target 0x80 while unheld → same cycle `redirect_valid` = 1, `redirect_pc` = 0x80, `flush` = 00110, `perf_redirects` = 1.
- `mem_stallreq` high for 3 cycles with a mispredict pulse (0x200) in the first → `stall` = 01111 for 3 cycles, then exactly one redirect to 0x200 in the 4th cycle.
- `mem_stallreq` and `ex_stallreq` together with LU → `stall` = 01111, `flush` = 10000.
- `MAX_STALL` = 4, `ex_stallreq` held 6 cycles → `stall_timeout` rises after cycle 4 and stays 1 after release until `rst` low.
- Enter PEND, pull `rst` low mid-hold → all outputs 0 immediately, no redirect after release, counters 0.
